// File: rtl/vga_text_writer_pkg.sv
// vga_text_pkg: character codes and FSM states shared by the text writer
package vga_text_pkg;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] PRINT_MAX  = 8'h7E;
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_e;
endpackage

// File: rtl/vga_text_writer.sv
// vga_text_writer: terminal-style character stream to VGA text buffer writes
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        char_write,
  output logic [ADDR_W-1:0] addr_write,
  output logic              write_enable
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  if (ROWS * COLS > 2 ** ADDR_W) begin : g_bad_params
    $error("ROWS*COLS exceeds the ADDR_W address space");
  end
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d, next_row;
  logic [CW-1:0] col_q, col_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, row_base, cur_addr;
  logic [7:0] char_q, char_d;
  logic we_q, we_d, clr_last, printable, col_wrap;
  assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign cur_addr = row_base + ADDR_W'(col_q);
  assign next_row = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign clr_last = (state_q == CLR_ALL) ? (cnt_q == LAST_ALL) : (cnt_q == LAST_COL);
  assign printable = (in_char >= PRINT_MIN) && (in_char <= PRINT_MAX);
  assign col_wrap = (col_q == CW'(COLS - 1));
  assign in_ready = (state_q == IDLE);
  assign char_write = char_q;
  assign addr_write = addr_q;
  assign write_enable = we_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    addr_d = addr_q;
    char_d = char_q;
    case (state_q)
      CLR_ALL, CLR_ROW: begin
        we_d = 1'b1;
        char_d = CHAR_SPACE;
        addr_d = (state_q == CLR_ALL) ? cnt_q : row_base + cnt_q;
        cnt_d = clr_last ? '0 : cnt_q + 1'b1;
        state_d = clr_last ? IDLE : state_q;
      end
      default: if (in_valid) begin
        if (printable) begin
          we_d = 1'b1;
          char_d = in_char;
          addr_d = cur_addr;
          col_d = col_wrap ? '0 : col_q + 1'b1;
          row_d = col_wrap ? next_row : row_q;
          state_d = col_wrap ? CLR_ROW : IDLE;
        end else if (in_char == CHAR_LF) begin
          col_d = '0;
          row_d = next_row;
          state_d = CLR_ROW;
        end else if (in_char == CHAR_CR) begin
          col_d = '0;
        end else if (in_char == CHAR_BS && col_q != '0) begin
          col_d = col_q - 1'b1;
          we_d = 1'b1;
          char_d = CHAR_SPACE;
          addr_d = cur_addr - 1'b1;
        end else if (in_char == CHAR_FF) begin
          row_d = '0;
          col_d = '0;
          state_d = CLR_ALL;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_ALL;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      char_q <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      char_q <= char_d;
    end
  end
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed table and sequence checks for vga_text_writer
module tb_vga_text_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_char = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, write_enable;
  logic [7:0] char_write;
  logic [5:0] addr_write;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] c;
    int we;
    int addr;
    int ch;
    int rdy;
  } vec_t;
  vec_t tbl[10];
  vga_text_writer #(.COLS(16), .ROWS(4), .ADDR_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .in_char(in_char),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .char_write(char_write),
    .addr_write(addr_write),
    .write_enable(write_enable)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string nm, input int we, input int addr, input int ch, input int rdy);
    chk({nm, "_we"}, int'(write_enable), we);
    if (we != 0) begin
      chk({nm, "_addr"}, int'(addr_write), addr);
      chk({nm, "_char"}, int'(char_write), ch);
    end
    chk({nm, "_ready"}, int'(in_ready), rdy);
  endtask
  task automatic expect_clear(input int start, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out("clear", 1, start + i, 'h20, (full && i == n - 1) ? 1 : 0);
    end
  endtask
  task automatic send(input logic [7:0] c, input int we, input int addr, input int ch, input int rdy);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_char = c;
    tick();
    in_valid = 1'b0;
    chk_out("send", we, addr, ch, rdy);
  endtask
  initial begin
    tbl[0] = '{8'h41, 1, 0, 'h41, 1};
    tbl[1] = '{8'h42, 1, 1, 'h42, 1};
    tbl[2] = '{8'h0D, 0, 0, 0, 1};
    tbl[3] = '{8'h07, 0, 0, 0, 1};
    tbl[4] = '{8'h08, 0, 0, 0, 1};
    tbl[5] = '{8'h43, 1, 0, 'h43, 1};
    tbl[6] = '{8'h44, 1, 1, 'h44, 1};
    tbl[7] = '{8'h45, 1, 2, 'h45, 1};
    tbl[8] = '{8'h08, 1, 2, 'h20, 1};
    tbl[9] = '{8'h46, 1, 2, 'h46, 1};
    tick();
    tick();
    chk("rst_we", int'(write_enable), 0);
    chk("rst_addr", int'(addr_write), 0);
    chk("rst_char", int'(char_write), 0);
    chk("rst_ready", int'(in_ready), 0);
    reset = 1'b0;
    expect_clear(0, 20, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_we", int'(write_enable), 0);
    chk("midrst_addr", int'(addr_write), 0);
    chk("midrst_ready", int'(in_ready), 0);
    reset = 1'b0;
    expect_clear(0, 64, 1'b1);
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_char = tbl[i].c;
      tick();
      chk_out("table", tbl[i].we, tbl[i].addr, tbl[i].ch, tbl[i].rdy);
    end
    in_valid = 1'b0;
    send(8'h0D, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_char = 8'h61 + 8'(i);
      tick();
      chk_out("row_fill", 1, i, 'h61 + i, (i < 15) ? 1 : 0);
    end
    in_valid = 1'b0;
    expect_clear(16, 16, 1'b1);
    send(8'h30, 1, 16, 'h30, 1);
    for (int i = 0; i < 6; i++) send(8'h31 + 8'(i), 1, 17 + i, 'h31 + i, 1);
    send(8'h0D, 0, 0, 0, 1);
    send(8'h51, 1, 16, 'h51, 1);
    send(8'h0A, 0, 0, 0, 0);
    expect_clear(32, 16, 1'b1);
    send(8'h08, 0, 0, 0, 1);
    send(8'h61, 1, 32, 'h61, 1);
    send(8'h62, 1, 33, 'h62, 1);
    send(8'h63, 1, 34, 'h63, 1);
    send(8'h08, 1, 34, 'h20, 1);
    send(8'h64, 1, 34, 'h64, 1);
    send(8'h0A, 0, 0, 0, 0);
    expect_clear(48, 16, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1, 48 + i, 'h70 + i, 1);
    send(8'h0A, 0, 0, 0, 0);
    expect_clear(0, 16, 1'b1);
    send(8'h58, 1, 0, 'h58, 1);
    send(8'h0A, 0, 0, 0, 0);
    in_valid = 1'b1;
    in_char = 8'h59;
    expect_clear(16, 16, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("held", 1, 16, 'h59, 1);
    tick();
    chk("no_dup_we", int'(write_enable), 0);
    send(8'h57, 1, 17, 'h57, 1);
    send(8'h0C, 0, 0, 0, 0);
    expect_clear(0, 64, 1'b1);
    send(8'h5A, 1, 0, 'h5A, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
